// File: rtl/dual_capture_buffer_pkg.sv
// rtl/dual_capture_buffer_pkg.sv - shared state encoding and default sizing for the dual capture buffer
package dual_capture_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FILL,
    ST_FULL,
    ST_HOLD
  } state_t;

  localparam int DEF_BUF_SIZE     = 500;
  localparam int DEF_BUF_SIZE_MSB = 8;
  localparam int DEF_ADC_MSB      = 11;
  localparam int DEF_TRIG_LEVEL   = 400;
  localparam int DEF_HOLDOFF      = 1000;

endpackage

// File: rtl/dual_capture_buffer_capture_ram.sv
// rtl/dual_capture_buffer_capture_ram.sv - one-write, one-async-read sample store for a single channel
module capture_ram #(
  parameter int DEPTH = 500,
  parameter int AW    = 9,
  parameter int DW    = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic signed [DW-1:0] rdata
);

  logic signed [DW-1:0] mem [DEPTH];

  // Storage is deliberately not reset so a capture survives a reset pulse.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Addresses past the end of the store read as zero; a same-cycle write is
  // not yet visible, so the old contents are returned.
  always_comb begin
    rdata = '0;
    if ({1'b0, raddr} < (AW+1)'(DEPTH)) rdata = mem[raddr];
  end

endmodule

// File: rtl/dual_capture_buffer.sv
// rtl/dual_capture_buffer.sv - triggered two-channel ADC capture with full/ready handshake and holdoff
module dual_capture_buffer
  import dual_capture_buffer_pkg::*;
#(
  parameter int BUF_SIZE     = DEF_BUF_SIZE,
  parameter int BUF_SIZE_MSB = DEF_BUF_SIZE_MSB,
  parameter int ADC_MSB      = DEF_ADC_MSB,
  parameter int TRIG_LEVEL   = DEF_TRIG_LEVEL,
  parameter int HOLDOFF      = DEF_HOLDOFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      adc_valid,
  input  logic signed [ADC_MSB:0]   adc_0,
  input  logic signed [ADC_MSB:0]   adc_1,
  input  logic [BUF_SIZE_MSB:0]     rd_address_0,
  input  logic [BUF_SIZE_MSB:0]     rd_address,
  output logic signed [ADC_MSB:0]   buffer_val_0,
  output logic signed [ADC_MSB:0]   buffer_val_1,
  output logic                      full,
  input  logic                      ready,
  output logic                      overrun
);

  localparam int AW   = BUF_SIZE_MSB + 1;
  localparam int DW   = ADC_MSB + 1;
  localparam int MW   = ADC_MSB + 2;
  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [AW-1:0]   LAST_ADDR = AW'(BUF_SIZE - 1);
  localparam logic [MW-1:0]   TRIG_MAG  = MW'(TRIG_LEVEL);
  localparam logic [HC_W-1:0] HOLD_LAST = (HOLDOFF > 1) ? HC_W'(HOLDOFF - 1) : '0;

  // One extra bit so the most negative sample has a representable magnitude.
  function automatic logic [MW-1:0] magnitude(input logic signed [DW-1:0] s);
    logic signed [MW-1:0] e;
    e = {s[DW-1], s};
    return e[MW-1] ? MW'(-e) : MW'(e);
  endfunction

  state_t          state;
  logic [AW-1:0]   wp;
  logic [HC_W-1:0] hold_cnt;
  logic [MW-1:0]   mag_0;
  logic [MW-1:0]   mag_1;
  logic            trig;
  logic            we;
  logic [AW-1:0]   waddr;

  assign mag_0 = magnitude(adc_0);
  assign mag_1 = magnitude(adc_1);

  // Trigger qualification and write-port steering; the trigger pair lands at 0.
  always_comb begin
    trig  = enable && adc_valid && ((mag_0 >= TRIG_MAG) || (mag_1 >= TRIG_MAG));
    we    = ((state == ST_ARM) && trig) || ((state == ST_FILL) && adc_valid);
    waddr = (state == ST_FILL) ? wp : '0;
  end

  // Capture sequencing: arm, fill without wrap, hold until released, back off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wp       <= '0;
      hold_cnt <= '0;
      full     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_ARM;
        ST_ARM: begin
          if (trig) begin
            overrun <= 1'b0;
            if (BUF_SIZE == 1) begin
              state <= ST_FULL;
              full  <= 1'b1;
            end else begin
              state <= ST_FILL;
              wp    <= AW'(1);
            end
          end
        end
        ST_FILL: begin
          if (adc_valid) begin
            if (wp == LAST_ADDR) begin
              state <= ST_FULL;
              full  <= 1'b1;
            end else begin
              wp <= wp + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (adc_valid) overrun <= 1'b1;
          if (ready) begin
            state    <= ST_HOLD;
            full     <= 1'b0;
            hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= ST_ARM;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  capture_ram #(.DEPTH(BUF_SIZE), .AW(AW), .DW(DW)) u_ram_0 (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (adc_0),
    .raddr (rd_address_0),
    .rdata (buffer_val_0)
  );

  capture_ram #(.DEPTH(BUF_SIZE), .AW(AW), .DW(DW)) u_ram_1 (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (adc_1),
    .raddr (rd_address),
    .rdata (buffer_val_1)
  );

endmodule

// File: tb/tb_dual_capture_buffer.sv
// tb/tb_dual_capture_buffer.sv - self-checking bench for dual_capture_buffer
module tb_dual_capture_buffer;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               adc_valid;
  logic signed [11:0] adc_0;
  logic signed [11:0] adc_1;
  logic [8:0]         rd_address_0;
  logic [8:0]         rd_address;
  logic signed [11:0] buffer_val_0;
  logic signed [11:0] buffer_val_1;
  logic               full;
  logic               ready;
  logic               overrun;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int    a0;
    int    a1;
    int    e0;
    int    e1;
    string name;
  } rd_vec_t;

  typedef struct {
    int addr;
    int v0;
    int v1;
  } sb_t;

  rd_vec_t vecs[6];
  sb_t     sb_q[$];

  dual_capture_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .adc_valid    (adc_valid),
    .adc_0        (adc_0),
    .adc_1        (adc_1),
    .rd_address_0 (rd_address_0),
    .rd_address   (rd_address),
    .buffer_val_0 (buffer_val_0),
    .buffer_val_1 (buffer_val_1),
    .full         (full),
    .ready        (ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int a0, input int a1);
    adc_valid = v;
    adc_0     = 12'(a0);
    adc_1     = 12'(a1);
  endtask

  task automatic read_both(input int a0, input int a1, output int r0, output int r1);
    rd_address_0 = 9'(a0);
    rd_address   = 9'(a1);
    #1;
    r0 = int'(buffer_val_0);
    r1 = int'(buffer_val_1);
  endtask

  task automatic push(input int addr, input int v0, input int v1);
    sb_t e;
    e.addr = addr;
    e.v0   = v0;
    e.v1   = v1;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    sb_t e;
    int  r0, r1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      read_both(e.addr, e.addr, r0, r1);
      check($sformatf("%s ch0[%0d]", tag, e.addr), r0, e.v0);
      check($sformatf("%s ch1[%0d]", tag, e.addr), r1, e.v1);
    end
  endtask

  task automatic run_table(input string tag);
    int r0, r1;
    for (int k = 0; k < 6; k++) begin
      read_both(vecs[k].a0, vecs[k].a1, r0, r1);
      check($sformatf("%s %s ch0", tag, vecs[k].name), r0, vecs[k].e0);
      check($sformatf("%s %s ch1", tag, vecs[k].name), r1, vecs[k].e1);
    end
  endtask

  initial begin
    int r0, r1;

    vecs[0] = '{a0: 0,   a1: 0,   e0: 5,   e1: -400, name: "addr0"};
    vecs[1] = '{a0: 13,  a1: 13,  e0: 13,  e1: -13,  name: "addr13"};
    vecs[2] = '{a0: 499, a1: 499, e0: 499, e1: -499, name: "addr499"};
    vecs[3] = '{a0: 500, a1: 511, e0: 0,   e1: 0,    name: "oob500_511"};
    vecs[4] = '{a0: 511, a1: 500, e0: 0,   e1: 0,    name: "oob511_500"};
    vecs[5] = '{a0: 250, a1: 1,   e0: 250, e1: -1,   name: "mixed"};

    rst = 1'b1; enable = 1'b0; ready = 1'b0;
    rd_address_0 = '0; rd_address = '0;
    drive(0, 0, 0);
    repeat (3) step();
    check("reset full", int'(full), 0);
    check("reset overrun", int'(overrun), 0);

    // Sub-threshold traffic must never trigger.
    rst = 1'b0; enable = 1'b1;
    drive(1, 100, -100);
    repeat (20) step();
    check("no trigger full", int'(full), 0);
    drive(1, 399, -399);
    step();
    check("399 no trigger full", int'(full), 0);

    // Trigger on channel 1 at exactly the threshold, then 499 more pairs.
    drive(1, 5, -400);
    push(0, 5, -400);
    step();
    for (int i = 1; i < 500; i++) begin
      if (i % 7 == 0) begin
        drive(0, 1234, 1234);
        step();
      end
      enable = (i >= 100 && i < 300) ? 1'b0 : 1'b1;
      drive(1, i, -i);
      push(i, i, -i);
      step();
      if (i == 498) check("full before last write", int'(full), 0);
      if (i == 499) check("full after last write", int'(full), 1);
    end
    drive(0, 0, 0);
    enable = 1'b1;
    check("overrun quiet full", int'(overrun), 0);
    drain("fill1");
    run_table("full");

    // Samples arriving while full are discarded and flagged.
    step();
    drive(1, 2000, -2000);
    repeat (10) step();
    drive(0, 0, 0);
    check("full held", int'(full), 1);
    check("overrun set", int'(overrun), 1);
    run_table("after overrun");

    // Release, then time the holdoff by when overrun clears on re-trigger.
    step();
    drive(1, 1000, 7);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("full cleared after ready", int'(full), 0);
    for (int k = 1; k <= 1000; k++) step();
    check("overrun held through holdoff", int'(overrun), 1);
    read_both(0, 0, r0, r1);
    check("no write during hold ch0", r0, 5);
    step();
    check("overrun cleared on trigger", int'(overrun), 0);
    check("full low in fill", int'(full), 0);
    read_both(0, 0, r0, r1);
    check("retrigger addr0 ch0", r0, 1000);
    check("retrigger addr0 ch1", r1, 7);

    // Abort the fill with reset after 250 writes; storage must survive.
    for (int i = 1; i < 250; i++) begin
      drive(1, 50 + i, -50 - i);
      step();
    end
    rst = 1'b1;
    drive(1, 77, 77);
    step();
    check("mid-fill reset full", int'(full), 0);
    check("mid-fill reset overrun", int'(overrun), 0);
    read_both(300, 100, r0, r1);
    check("kept addr300 ch0", r0, 300);
    check("kept addr100 ch1", r1, -150);

    // Restart: ready is ignored outside FULL, trigger on -2048 lands at 0.
    rst = 1'b0;
    ready = 1'b1;
    drive(1, 0, 0);
    step();
    step();
    drive(1, -2048, 0);
    push(0, -2048, 0);
    step();
    for (int i = 1; i < 500; i++) begin
      ready = (i < 400) ? 1'b1 : 1'b0;
      drive(1, i * 4 - 1000, 1000 - i * 4);
      push(i, i * 4 - 1000, 1000 - i * 4);
      if (i == 10) begin
        read_both(10, 10, r0, r1);
        check("read during write old ch0", r0, 60);
        check("read during write old ch1", r1, -60);
      end
      step();
      if (i == 499) check("refill full", int'(full), 1);
    end
    drive(0, 0, 0);
    ready = 1'b0;
    drain("fill2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
